// File: rtl/permuter_swap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : permuter_swap_ctrl                                              |
// | Purpose  : Stages two flits, arbitrates golden > older > round-robin, and  |
// |            emits a registered swap bit aligned with the staged flits.      |
// | Options  : SWAP_STATS_EN enables the saturating deflection counter.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module permuter_swap_ctrl #(
  parameter int WIDTH     = 32,
  parameter int AGE_W     = 8,
  parameter int ID_W      = 4,
  parameter int NUM_NODES = 16,
  parameter int EPOCH_LEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_flit0,
  input  logic [WIDTH-1:0] in_flit1,
  input  logic             in_valid0,
  input  logic             in_valid1,
  input  logic [AGE_W-1:0] in_age0,
  input  logic [AGE_W-1:0] in_age1,
  input  logic [ID_W-1:0]  in_src0,
  input  logic [ID_W-1:0]  in_src1,
  input  logic             in_dir0,
  input  logic             in_dir1,
  output logic [WIDTH-1:0] out_flit0,
  output logic [WIDTH-1:0] out_flit1,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             swap,
  output logic [ID_W-1:0]  golden_id,
  output logic [15:0]      deflect_cnt
);

  localparam int            c_EPOCH_W   = (EPOCH_LEN > 2) ? $clog2(EPOCH_LEN) : 1;
  localparam [c_EPOCH_W-1:0] c_EPOCH_LAST = c_EPOCH_W'(EPOCH_LEN - 1);
  localparam [ID_W-1:0]      c_ID_LAST    = ID_W'(NUM_NODES - 1);

  logic [c_EPOCH_W-1:0] r_epochCnt;
  logic [ID_W-1:0]      r_goldenId;
  logic                 r_tiePtr;

  logic w_gold0;
  logic w_gold1;
  logic w_bothValid;
  logic w_winner;
  logic w_tieCycle;
  logic w_swapNext;

  // Golden match uses the current (pre-update) golden ID.
  assign w_gold0     = in_valid0 && (in_src0 == r_goldenId);
  assign w_gold1     = in_valid1 && (in_src1 == r_goldenId);
  assign w_bothValid = in_valid0 && in_valid1;

  always_comb begin
    w_winner   = 1'b0;
    w_tieCycle = 1'b0;
    w_swapNext = 1'b0;
    if (w_bothValid) begin
      if (w_gold0 ^ w_gold1) begin
        w_winner = w_gold1;
      end else if (in_age0 != in_age1) begin
        w_winner = (in_age1 > in_age0);
      end else begin
        w_winner   = r_tiePtr;
        w_tieCycle = 1'b1;
      end
      w_swapNext = w_winner ? ~in_dir1 : in_dir0;
    end else if (in_valid0) begin
      w_swapNext = in_dir0;
    end else if (in_valid1) begin
      w_swapNext = ~in_dir1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_epochCnt <= '0;
      r_goldenId <= '0;
      r_tiePtr   <= 1'b0;
    end else begin
      if (r_epochCnt == c_EPOCH_LAST) begin
        r_epochCnt <= '0;
        r_goldenId <= (r_goldenId == c_ID_LAST) ? '0 : r_goldenId + 1'b1;
      end else begin
        r_epochCnt <= r_epochCnt + 1'b1;
      end
      if (w_tieCycle) begin
        r_tiePtr <= ~r_tiePtr;
      end
    end
  end

  // Flits stay on their own lane; the downstream permuter applies swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_flit0  <= '0;
      out_flit1  <= '0;
      out_valid0 <= 1'b0;
      out_valid1 <= 1'b0;
      swap       <= 1'b0;
    end else begin
      out_flit0  <= in_flit0;
      out_flit1  <= in_flit1;
      out_valid0 <= in_valid0;
      out_valid1 <= in_valid1;
      swap       <= w_swapNext;
    end
  end

  assign golden_id = r_goldenId;

`ifdef SWAP_STATS_EN
  logic        w_deflect;
  logic [15:0] r_deflectCnt;

  assign w_deflect = w_bothValid && (in_dir0 == in_dir1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deflectCnt <= 16'h0;
    end else if (w_deflect && (r_deflectCnt != 16'hFFFF)) begin
      r_deflectCnt <= r_deflectCnt + 16'h1;
    end
  end

  assign deflect_cnt = r_deflectCnt;
`else
  assign deflect_cnt = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_permuter_swap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_permuter_swap_ctrl                                           |
// | Purpose  : Scoreboard bench for permuter_swap_ctrl (small epoch/node set). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_permuter_swap_ctrl;

  localparam int WIDTH     = 16;
  localparam int AGE_W     = 8;
  localparam int ID_W      = 4;
  localparam int NUM_NODES = 3;
  localparam int EPOCH_LEN = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_flit0, in_flit1;
  logic             in_valid0, in_valid1;
  logic [AGE_W-1:0] in_age0, in_age1;
  logic [ID_W-1:0]  in_src0, in_src1;
  logic             in_dir0, in_dir1;
  logic [WIDTH-1:0] out_flit0, out_flit1;
  logic             out_valid0, out_valid1;
  logic             swap;
  logic [ID_W-1:0]  golden_id;
  logic [15:0]      deflect_cnt;

  typedef struct {
    logic [WIDTH-1:0] f0;
    logic [WIDTH-1:0] f1;
    logic             v0;
    logic             v1;
    logic             sw;
    logic [ID_W-1:0]  gid;
    logic [15:0]      dc;
  } exp_t;

  exp_t sbq[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Reference state of the arbiter
  int   mEpoch, mGolden, mTie, mDefl;

  permuter_swap_ctrl #(
    .WIDTH(WIDTH), .AGE_W(AGE_W), .ID_W(ID_W),
    .NUM_NODES(NUM_NODES), .EPOCH_LEN(EPOCH_LEN)
  ) dut (
    .clk(clk), .reset(reset),
    .in_flit0(in_flit0), .in_flit1(in_flit1),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_age0(in_age0), .in_age1(in_age1),
    .in_src0(in_src0), .in_src1(in_src1),
    .in_dir0(in_dir0), .in_dir1(in_dir1),
    .out_flit0(out_flit0), .out_flit1(out_flit1),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .swap(swap), .golden_id(golden_id), .deflect_cnt(deflect_cnt)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mEpoch = 0; mGolden = 0; mTie = 0; mDefl = 0;
    sbq.delete();
  endtask

  // Called at a negedge: apply inputs, push the expected post-edge outputs,
  // return at the following negedge.
  task automatic drive(input logic v0, input logic v1, input logic d0, input logic d1,
                       input int a0, input int a1, input int s0, input int s1,
                       input logic [WIDTH-1:0] f0, input logic [WIDTH-1:0] f1);
    exp_t e;
    logic g0, g1, w;
    in_valid0 = v0; in_valid1 = v1; in_dir0 = d0; in_dir1 = d1;
    in_age0 = AGE_W'(a0); in_age1 = AGE_W'(a1);
    in_src0 = ID_W'(s0);  in_src1 = ID_W'(s1);
    in_flit0 = f0; in_flit1 = f1;
    g0 = v0 && (s0 == mGolden);
    g1 = v1 && (s1 == mGolden);
    e.sw = 1'b0;
    if (v0 && v1) begin
      if (g0 != g1)      w = g1;
      else if (a0 != a1) w = (a1 > a0);
      else begin
        w = mTie[0];
        mTie = 1 - mTie;
      end
      e.sw = ((w ? d1 : d0) != w);
    end else if (v0) begin
      e.sw = (d0 != 1'b0);
    end else if (v1) begin
      e.sw = (d1 != 1'b1);
    end
`ifdef SWAP_STATS_EN
    if (v0 && v1 && (d0 == d1) && (mDefl != 65535)) mDefl++;
`endif
    if (mEpoch == EPOCH_LEN - 1) begin
      mEpoch  = 0;
      mGolden = (mGolden == NUM_NODES - 1) ? 0 : mGolden + 1;
    end else begin
      mEpoch++;
    end
    e.f0 = f0; e.f1 = f1; e.v0 = v0; e.v1 = v1;
    e.gid = ID_W'(mGolden);
    e.dc  = 16'(mDefl);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 15, 15, '0, '0);
  endtask

  // Scoreboard: compare every registered result one step after its edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      nChecks++;
      if (swap !== e.sw || out_valid0 !== e.v0 || out_valid1 !== e.v1 ||
          out_flit0 !== e.f0 || out_flit1 !== e.f1 ||
          golden_id !== e.gid || deflect_cnt !== e.dc) begin
        nFails++;
        $display("FAIL sb got sw=%0b v=%0b%0b f=%h/%h gid=%0d dc=%0d want sw=%0b v=%0b%0b f=%h/%h gid=%0d dc=%0d",
                 swap, out_valid0, out_valid1, out_flit0, out_flit1, golden_id, deflect_cnt,
                 e.sw, e.v0, e.v1, e.f0, e.f1, e.gid, e.dc);
      end
    end
  end

  task automatic test_reset();
    modelReset();
    reset = 1'b0;
    // traffic that moves golden_id, deflect_cnt and the outputs off zero
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5, 9, 14, 13, 16'hA000 + 16'(i), 16'hB000 + 16'(i));
    reset = 1'b1;
    in_valid0 = 1'b1; in_valid1 = 1'b1;
    #1;
    nChecks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || swap !== 1'b0 || out_flit0 !== '0 ||
        out_flit1 !== '0 || golden_id !== '0 || deflect_cnt !== 16'h0) begin
      nFails++;
      $display("FAIL reset_async got v=%0b%0b sw=%0b f=%h/%h gid=%0d dc=%0d want all 0",
               out_valid0, out_valid1, swap, out_flit0, out_flit1, golden_id, deflect_cnt);
    end
    @(negedge clk);
    nChecks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || golden_id !== '0) begin
      nFails++;
      $display("FAIL reset_held got v=%0b%0b gid=%0d want 0 0 0", out_valid0, out_valid1, golden_id);
    end
    reset = 1'b0;
    modelReset();
    idle();
    nChecks++;
    if (out_valid0 !== 1'b0) begin
      nFails++;
      $display("FAIL reset_idle out_valid0 got %0b want 0", out_valid0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 14, 14, 16'h1234, 16'h0);
    nChecks++;
    if (out_valid0 !== 1'b1 || out_flit0 !== 16'h1234) begin
      nFails++;
      $display("FAIL reset_first_valid got v0=%0b f0=%h want 1 1234", out_valid0, out_flit0);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4, 0, 14, 14, 16'hC0DE, 16'h5555);
    nChecks++;
    if (swap !== 1'b1 || out_valid0 !== 1'b1 || out_valid1 !== 1'b0 || out_flit0 !== 16'hC0DE) begin
      nFails++;
      $display("FAIL single_dir1 got sw=%0b v=%0b%0b f0=%h want 1 10 c0de", swap, out_valid0, out_valid1, out_flit0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4, 0, 14, 14, 16'hBEEF, 16'h0);
    nChecks++;
    if (swap !== 1'b0) begin
      nFails++;
      $display("FAIL single_dir0 swap got %0b want 0", swap);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 4, 14, 14, 16'h0, 16'h7777);
    nChecks++;
    if (swap !== 1'b1 || out_valid1 !== 1'b1 || out_flit1 !== 16'h7777) begin
      nFails++;
      $display("FAIL single_lane1 got sw=%0b v1=%0b f1=%h want 1 1 7777", swap, out_valid1, out_flit1);
    end
  endtask

  task automatic test_age();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 9, 14, 13, 16'h0003, 16'h0009);
    nChecks++;
    if (swap !== 1'b1) begin
      nFails++;
      $display("FAIL age_swap got %0b want 1", swap);
    end
    nChecks++;
`ifdef SWAP_STATS_EN
    if (deflect_cnt !== 16'd1) begin
      nFails++;
      $display("FAIL age_deflect got %0d want 1", deflect_cnt);
    end
`else
    if (deflect_cnt !== 16'd0) begin
      nFails++;
      $display("FAIL age_deflect got %0d want 0", deflect_cnt);
    end
`endif
  endtask

  task automatic test_golden();
    int g, o;
    g = mGolden;
    o = (mGolden + 1) % NUM_NODES;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 0, 200, g, o, 16'h6060, 16'h2020);
    nChecks++;
    if (swap !== 1'b1) begin
      nFails++;
      $display("FAIL golden_lane0 swap got %0b want 1", swap);
    end
    g = mGolden;
    o = (mGolden + 2) % NUM_NODES;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 200, 0, o, g, 16'h1111, 16'h2222);
    nChecks++;
    if (swap !== 1'b0) begin
      nFails++;
      $display("FAIL golden_lane1 swap got %0b want 0", swap);
    end
  endtask

  task automatic test_tie();
    logic [3:0] want;
    want = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7, 7, 14, 13, 16'(i), 16'(i + 8));
      nChecks++;
      if (swap !== want[3 - i]) begin
        nFails++;
        $display("FAIL tie_%0d swap got %0b want %0b", i, swap, want[3 - i]);
      end
    end
  endtask

  task automatic test_epoch();
    int want;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    for (int k = 1; k <= 12; k++) begin
      idle();
      want = (k / 4) % 3;
      nChecks++;
      if (golden_id !== ID_W'(want)) begin
        nFails++;
        $display("FAIL epoch_cycle%0d golden_id got %0d want %0d", k, golden_id, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 48; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            16'($urandom), 16'($urandom));
    idle();
  endtask

  initial begin
    reset = 1'b1;
    in_flit0 = '0; in_flit1 = '0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_age0 = '0; in_age1 = '0; in_src0 = '0; in_src1 = '0;
    in_dir0 = 1'b0; in_dir1 = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_age();
    test_golden();
    test_tie();
    test_epoch();
    test_back_to_back();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
